// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Front-end pipeline stage: owns the program counter, reads the combinational
// instruction memory, and holds the IF/ID pipeline register that feeds the
// decoder. Sequences start/halt through a small IDLE/RUN/HALTED FSM, applies
// branch/jump redirects and hazard stalls, and counts retired fetches.
//
// Ports:
//   clk             in   clock, rising-edge active
//   rst_n           in   asynchronous active-low reset
//   go              in   one-cycle pulse, (re)starts execution at RESET_PC
//   imem_addr       out  instruction memory address (always equals PC)
//   imem_rdata      in   instruction at imem_addr, same cycle
//   stall           in   hold PC and IF/ID for a hazard
//   branch_taken    in   redirect request from execute
//   branch_target   in   absolute redirect address
//   halt_in         in   halt opcode decoded from instruction_out
//   instruction_out out  IF/ID instruction (BUBBLE when invalid)
//   pc_out          out  PC of instruction_out
//   valid_out       out  instruction_out holds a real instruction
//   running         out  FSM is in RUN
//   done            out  FSM is in HALTED
//   fetch_count     out  valid fetches since the last go (saturating)
// -----------------------------------------------------------------------------
module instruction_fetch #(
    parameter int unsigned                 PC_WIDTH    = 8,
    parameter int unsigned                 INSTR_WIDTH = 9,
    parameter logic [PC_WIDTH-1:0]         RESET_PC    = '0,
    parameter int unsigned                 CNT_WIDTH   = 16,
    parameter logic [INSTR_WIDTH-1:0]      BUBBLE      = 9'b110110000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   go,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    input  logic                   halt_in,
    output logic [INSTR_WIDTH-1:0] instruction_out,
    output logic [PC_WIDTH-1:0]    pc_out,
    output logic                   valid_out,
    output logic                   running,
    output logic                   done,
    output logic [CNT_WIDTH-1:0]   fetch_count
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } state_t;

    localparam logic [PC_WIDTH-1:0]  PC_ONE  = 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    state_t                 state;
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic [PC_WIDTH-1:0]    pc_q;
    logic                   valid_q;
    logic                   running_q;
    logic                   done_q;
    logic [CNT_WIDTH-1:0]   count_q;

    // The memory is read combinationally, so the address is the live PC.
    assign imem_addr       = pc;
    assign instruction_out = instr_q;
    assign pc_out          = pc_q;
    assign valid_out       = valid_q;
    assign running         = running_q;
    assign done            = done_q;
    assign fetch_count     = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            instr_q   <= BUBBLE;
            pc_q      <= '0;
            valid_q   <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            case (state)
                // IDLE and HALTED behave identically apart from the done flag:
                // both hold a bubble and a frozen PC until go restarts them.
                IDLE, HALTED: begin
                    instr_q <= BUBBLE;
                    valid_q <= 1'b0;
                    if (go) begin
                        state     <= RUN;
                        pc        <= RESET_PC;
                        count_q   <= '0;
                        running_q <= 1'b1;
                        done_q    <= 1'b0;
                    end
                end

                RUN: begin
                    if (halt_in && valid_q) begin
                        // The halt instruction is already in IF/ID, so PC
                        // already points one past it; leave it there.
                        state     <= HALTED;
                        instr_q   <= BUBBLE;
                        valid_q   <= 1'b0;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else if (branch_taken) begin
                        // Redirect wins over stall: the instruction being
                        // fetched is wrong-path and must be squashed.
                        pc      <= branch_target;
                        instr_q <= BUBBLE;
                        valid_q <= 1'b0;
                    end else if (!stall) begin
                        instr_q <= imem_rdata;
                        pc_q    <= pc;
                        valid_q <= 1'b1;
                        pc      <= pc + PC_ONE;
                        if (count_q != '1) begin
                            count_q <= count_q + CNT_ONE;
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    instr_q   <= BUBBLE;
                    valid_q   <= 1'b0;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    localparam int CW      = 4;              // small counter so saturation is reachable
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam logic [8:0] BUB  = 9'b110110000;
    localparam logic [8:0] HALT = 9'b110100000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          go = 1'b0;
    logic [7:0]    imem_addr;
    logic [8:0]    imem_rdata;
    logic          stall = 1'b0;
    logic          branch_taken = 1'b0;
    logic [7:0]    branch_target = '0;
    logic          halt_in;
    logic          halt_drv = 1'b0;
    logic          loop_en = 1'b0;
    logic [8:0]    instruction_out;
    logic [7:0]    pc_out;
    logic          valid_out;
    logic          running;
    logic          done;
    logic [CW-1:0] fetch_count;

    logic [8:0] imem [256];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem[imem_addr];
    // Loop-back decoder: halt opcode is the top five bits 11010.
    assign halt_in = halt_drv | (loop_en && instruction_out[8:4] == 5'b11010);

    instruction_fetch #(
        .PC_WIDTH   (8),
        .INSTR_WIDTH(9),
        .RESET_PC   (8'h00),
        .CNT_WIDTH  (CW),
        .BUBBLE     (BUB)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .go             (go),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .halt_in        (halt_in),
        .instruction_out(instruction_out),
        .pc_out         (pc_out),
        .valid_out      (valid_out),
        .running        (running),
        .done           (done),
        .fetch_count    (fetch_count)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input bit ev, input int ei, input int ep,
                             input int ea, input int ec, input bit er, input bit ed);
        chk({tag, ".valid"}, int'(valid_out), int'(ev));
        chk({tag, ".instr"}, int'(instruction_out), ei);
        if (ev) chk({tag, ".pc_out"}, int'(pc_out), ep);
        chk({tag, ".addr"}, int'(imem_addr), ea);
        chk({tag, ".count"}, int'(fetch_count), ec);
        chk({tag, ".running"}, int'(running), int'(er));
        chk({tag, ".done"}, int'(done), int'(ed));
    endtask

    typedef struct {
        bit         go, st, br, ha;
        logic [7:0] tgt;
        bit         ev;
        int         ei, ep, ea, ec;
        bit         er, ed;
    } vec_t;

    function automatic vec_t mk(bit g, bit s, bit b, bit h, int t,
                                bit ev, int ei, int ep, int ea, int ec, bit er, bit ed);
        vec_t v;
        v.go = g; v.st = s; v.br = b; v.ha = h; v.tgt = 8'(t);
        v.ev = ev; v.ei = ei; v.ep = ep; v.ea = ea; v.ec = ec; v.er = er; v.ed = ed;
        return v;
    endfunction

    // Reference model: plain bookkeeping of the architectural rules.
    int m_mode;   // 0 idle, 1 run, 2 halted
    int m_pc, m_instr, m_ppc, m_cnt;
    bit m_v;

    task automatic model_reset();
        m_mode = 0; m_pc = 0; m_instr = int'(BUB); m_ppc = 0; m_cnt = 0; m_v = 0;
    endtask

    task automatic model_step(input bit g, input bit s, input bit b, input int t, input bit h);
        if (m_mode != 1) begin
            if (g) begin
                m_mode = 1; m_pc = 0; m_cnt = 0;
            end
            m_v = 0; m_instr = int'(BUB);
        end else if (h && m_v) begin
            m_mode = 2; m_v = 0; m_instr = int'(BUB);
        end else if (b) begin
            m_pc = t; m_v = 0; m_instr = int'(BUB);
        end else if (!s) begin
            m_instr = int'(imem[m_pc]);
            m_ppc   = m_pc;
            m_v     = 1;
            m_pc    = (m_pc + 1) % 256;
            m_cnt   = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        end
    endtask

    vec_t tbl[$];

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 9'(i + 16);
        imem[3] = HALT;

        // Row: go st br ha tgt | valid instr pc addr count run done
        tbl.push_back(mk(1,0,0,0,8'h00, 0,BUB,  0,   8'h00,0,1,0));
        tbl.push_back(mk(0,0,0,0,8'h00, 1,9'h010,0,  8'h01,1,1,0));
        tbl.push_back(mk(0,0,0,0,8'h00, 1,9'h011,1,  8'h02,2,1,0));
        tbl.push_back(mk(0,0,0,0,8'h00, 1,9'h012,2,  8'h03,3,1,0));
        tbl.push_back(mk(0,0,0,0,8'h00, 1,HALT,  3,  8'h04,4,1,0));
        tbl.push_back(mk(0,0,0,0,8'h00, 0,BUB,  0,   8'h04,4,0,1));
        tbl.push_back(mk(0,1,1,1,8'h40, 0,BUB,  0,   8'h04,4,0,1));
        tbl.push_back(mk(1,0,0,0,8'h00, 0,BUB,  0,   8'h00,0,1,0));
        tbl.push_back(mk(0,0,0,1,8'h00, 1,9'h010,0,  8'h01,1,1,0));
        tbl.push_back(mk(0,1,1,0,8'h40, 0,BUB,  0,   8'h40,1,1,0));
        tbl.push_back(mk(0,0,0,0,8'h00, 1,9'h050,8'h40,8'h41,2,1,0));
        tbl.push_back(mk(0,0,1,0,8'h04, 0,BUB,  0,   8'h04,2,1,0));
        tbl.push_back(mk(0,0,0,0,8'h00, 1,9'h014,4,  8'h05,3,1,0));
        tbl.push_back(mk(0,1,0,0,8'h00, 1,9'h014,4,  8'h05,3,1,0));
        tbl.push_back(mk(0,1,0,0,8'h00, 1,9'h014,4,  8'h05,3,1,0));
        tbl.push_back(mk(0,1,0,0,8'h00, 1,9'h014,4,  8'h05,3,1,0));
        tbl.push_back(mk(0,0,0,0,8'h00, 1,9'h015,5,  8'h06,4,1,0));
        tbl.push_back(mk(0,0,1,0,8'hFF, 0,BUB,  0,   8'hFF,4,1,0));
        tbl.push_back(mk(0,0,0,0,8'h00, 1,9'h10F,8'hFF,8'h00,5,1,0));
        tbl.push_back(mk(0,0,0,0,8'h00, 1,9'h010,0,  8'h01,6,1,0));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 0, int'(BUB), 0, 0, 0, 0, 0);
        chk("reset.pc_out", int'(pc_out), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table, halt looped back from instruction_out
        loop_en = 1'b1;
        foreach (tbl[i]) begin
            go = tbl[i].go; stall = tbl[i].st; branch_taken = tbl[i].br;
            halt_drv = tbl[i].ha; branch_target = tbl[i].tgt;
            @(posedge clk);
            #1;
            check_all($sformatf("row%0d", i), tbl[i].ev, tbl[i].ei, tbl[i].ep,
                      tbl[i].ea, tbl[i].ec, tbl[i].er, tbl[i].ed);
        end
        go = 0; stall = 0; branch_taken = 0; halt_drv = 0; loop_en = 1'b0;

        // Asynchronous reset between edges while running
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 0, int'(BUB), 0, 0, 0, 0, 0);
        chk("async_rst.pc_out", int'(pc_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check_all($sformatf("idle%0d", k), 0, int'(BUB), 0, 0, 0, 0, 0);
        end

        // Long run: saturating count, go ignored while running
        go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        check_all("sat_go", 0, int'(BUB), 0, 0, 0, 1, 0);
        for (int k = 1; k <= 20; k++) begin
            go = (k == 10);
            @(posedge clk);
            #1;
            check_all($sformatf("sat%0d", k), 1, int'(imem[k-1]), k - 1, k,
                      (k < CNT_MAX) ? k : CNT_MAX, 1, 0);
        end
        go = 1'b0;

        // Randomized run against the reference model
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 256; i++) imem[i] = 9'($urandom);
        for (int c = 0; c < 3000; c++) begin
            go            = ($urandom_range(0, 99) < 4);
            stall         = ($urandom_range(0, 99) < 25);
            branch_taken  = ($urandom_range(0, 99) < 10);
            branch_target = 8'($urandom);
            halt_drv      = ($urandom_range(0, 99) < 6);
            @(posedge clk);
            model_step(go, stall, branch_taken, int'(branch_target), halt_drv);
            #1;
            check_all($sformatf("rnd%0d", c), m_v, m_instr, m_ppc, m_pc, m_cnt,
                      m_mode == 1, m_mode == 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
